unidade_load_store: RTL

UNIDADE_LOAD_STORE -- requirements
Module: unidade_load_store

---
 rtl/unidade_load_store.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/unidade_load_store.sv
`default_nettype none
// ============================================================================
// Module      : unidade_load_store
// Description : Load/store unit with a three-state IDLE/ACCESS/RESP sequencer.
//               It drives a fixed-latency data memory, aligns store data and
//               byte enables to the lane, and extends load data.
//               Optional build macro: MISALIGN_TRAP_EN makes misaligned
//               accesses return an error instead of being force-aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_load_store #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int c_NUM_BYTES = XLEN / 8;
    localparam int c_OFF_W     = $clog2(c_NUM_BYTES);
    localparam int c_CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;

    logic [ADDR_W-1:0]      r_addr;
    logic [1:0]             r_size;
    logic                   r_we;
    logic                   r_unsigned;
    logic                   r_err;
    logic [XLEN-1:0]        r_wdata;
    logic [XLEN-1:0]        r_rdata;
    logic [c_CNT_W-1:0]     r_latCnt;

    logic [2:0]             w_alignMask;
    logic                   w_sizeBad;
    logic                   w_reqErr;
    logic [ADDR_W-1:0]      w_effAddr;
    logic                   w_accept;
    logic                   w_inAccess;
    logic                   w_lastAccess;
    logic [c_OFF_W-1:0]     w_offset;
    logic [c_OFF_W+2:0]     w_shamt;
    logic [XLEN-1:0]        w_shifted;
    logic [XLEN-1:0]        w_loadExt;
    logic [c_NUM_BYTES-1:0] w_laneEn;

    // Address bits that must be zero for a naturally aligned access.
    always_comb begin
        w_alignMask = 3'b000;
        case (req_size)
            2'b00:   w_alignMask = 3'b000;
            2'b01:   w_alignMask = 3'b001;
            2'b10:   w_alignMask = 3'b011;
            default: w_alignMask = 3'b111;
        endcase
    end

    assign w_sizeBad = (XLEN == 32) && (req_size == 2'b11);

`ifdef MISALIGN_TRAP_EN
    assign w_reqErr  = w_sizeBad | (|(req_addr[2:0] & w_alignMask));
    assign w_effAddr = req_addr;
`else
    assign w_reqErr  = w_sizeBad;
    assign w_effAddr = req_addr & ~ADDR_W'(w_alignMask);
`endif

    assign w_accept     = req_valid && (r_state == IDLE);
    assign w_inAccess   = (r_state == ACCESS);
    // Stores need a single write cycle; loads wait out the memory latency.
    assign w_lastAccess = r_we || (r_latCnt == c_LAST_CNT);
    assign w_offset     = r_addr[c_OFF_W-1:0];
    assign w_shamt      = {w_offset, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_nextState = w_reqErr ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (w_lastAccess) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_size     <= '0;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_latCnt   <= '0;
        end else if (w_accept) begin
            r_addr     <= w_effAddr;
            r_size     <= req_size;
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_err      <= w_reqErr;
            r_wdata    <= req_wdata;
            r_rdata    <= '0;
            r_latCnt   <= '0;
        end else if (w_inAccess) begin
            r_latCnt <= r_latCnt + c_CNT_W'(1);
            if (!r_we && w_lastAccess) begin
                r_rdata <= w_loadExt;
            end
        end
    end

    // Bring the addressed bytes down to bit 0, then extend to full width.
    assign w_shifted = mem_rdata >> w_shamt;

    always_comb begin
        w_loadExt = w_shifted;
        case (r_size)
            2'b00: w_loadExt = r_unsigned ? XLEN'(w_shifted[7:0])
                                          : XLEN'($signed(w_shifted[7:0]));
            2'b01: w_loadExt = r_unsigned ? XLEN'(w_shifted[15:0])
                                          : XLEN'($signed(w_shifted[15:0]));
            2'b10: w_loadExt = r_unsigned ? XLEN'(w_shifted[31:0])
                                          : XLEN'($signed(w_shifted[31:0]));
            default: w_loadExt = w_shifted;
        endcase
    end

    always_comb begin
        w_laneEn = '0;
        for (int i = 0; i < c_NUM_BYTES; i++) begin
            w_laneEn[i] = (i < (1 << r_size));
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_err   = rsp_valid & r_err;
    assign rsp_rdata = (rsp_valid && !r_err) ? r_rdata : '0;

    // Memory-side outputs are qualified by state so reset clears them at once.
    assign mem_wr    = w_inAccess && r_we && (r_latCnt == '0);
    assign mem_addr  = w_inAccess ? {r_addr[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}} : '0;
    assign mem_wdata = mem_wr ? (r_wdata << w_shamt) : '0;
    assign mem_wmask = mem_wr ? (w_laneEn << w_offset) : '0;

endmodule
`default_nettype wire
